// File: rtl/mul4_err_pkg.sv
// -----------------------------------------------------------------------------
// mul4_err_pkg
// Shared definitions for the 4x4 approximate-multiplier error sweep:
// sweep FSM state encoding, operand/product/statistic widths, vector count.
// -----------------------------------------------------------------------------
package mul4_err_pkg;

   localparam int OPW   = 4;    // operand width
   localparam int PRW   = 8;    // product width
   localparam int CNTW  = 9;    // error count width (0..256)
   localparam int SUMW  = 16;   // absolute error sum width (max 65280)
   localparam int BIASW = 17;   // signed error sum width
   localparam int NVEC  = 256;  // number of operand pairs
   localparam int IDXW  = 2 * OPW;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mul4_err_acc.sv
// -----------------------------------------------------------------------------
// mul4_err_acc
// Per-vector error evaluation and statistics accumulation. Each cycle with
// vld=1 compares the multiplier product r against the exact a*b and updates
// the registered statistics. clr zeroes all statistics and has priority.
//
// Optional: define MUL4_ERR_BIAS_EN to add the signed error sum err_bias.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             clear all statistics
//   vld, a, b       aligned vector valid flag and its operands
//   r               product from the multiplier under test
//   err_cnt         vectors with r != a*b
//   err_sum         sum of |r - a*b|
//   max_err         largest |r - a*b|
//   worst_a/b       operands of the first vector reaching max_err
//   err_bias        (MUL4_ERR_BIAS_EN) sum of signed r - a*b
// -----------------------------------------------------------------------------
module mul4_err_acc
   import mul4_err_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             vld,
   input  logic [OPW-1:0]   a,
   input  logic [OPW-1:0]   b,
   input  logic [PRW-1:0]   r,
   output logic [CNTW-1:0]  err_cnt,
   output logic [SUMW-1:0]  err_sum,
   output logic [PRW-1:0]   max_err,
   output logic [OPW-1:0]   worst_a,
   output logic [OPW-1:0]   worst_b
`ifdef MUL4_ERR_BIAS_EN
   ,
   output logic signed [BIASW-1:0] err_bias
`endif
);

   logic [PRW-1:0]        exact;
   logic signed [PRW:0]   diff;
   logic [PRW-1:0]        abs_err;

   logic [CNTW-1:0]  err_cnt_q, err_cnt_d;
   logic [SUMW-1:0]  err_sum_q, err_sum_d;
   logic [PRW-1:0]   max_err_q, max_err_d;
   logic [OPW-1:0]   worst_a_q, worst_a_d;
   logic [OPW-1:0]   worst_b_q, worst_b_d;

   assign exact = {{(PRW-OPW){1'b0}}, a} * {{(PRW-OPW){1'b0}}, b};
   // Both operands are zero-extended so the 9-bit difference cannot overflow.
   assign diff  = $signed({1'b0, r}) - $signed({1'b0, exact});
   // |diff| is at most 255, so the magnitude always fits in 8 bits.
   assign abs_err = diff[PRW] ? PRW'(-diff) : diff[PRW-1:0];

   always_comb begin
      err_cnt_d = err_cnt_q;
      err_sum_d = err_sum_q;
      max_err_d = max_err_q;
      worst_a_d = worst_a_q;
      worst_b_d = worst_b_q;
      if (clr) begin
         err_cnt_d = '0;
         err_sum_d = '0;
         max_err_d = '0;
         worst_a_d = '0;
         worst_b_d = '0;
      end else if (vld) begin
         if (abs_err != '0) begin
            err_cnt_d = err_cnt_q + CNTW'(1);
         end
         err_sum_d = err_sum_q + SUMW'(abs_err);
         // Strictly greater: on ties the earliest (lowest index) vector wins.
         if (abs_err > max_err_q) begin
            max_err_d = abs_err;
            worst_a_d = a;
            worst_b_d = b;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
         err_sum_q <= '0;
         max_err_q <= '0;
         worst_a_q <= '0;
         worst_b_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
         err_sum_q <= err_sum_d;
         max_err_q <= max_err_d;
         worst_a_q <= worst_a_d;
         worst_b_q <= worst_b_d;
      end
   end

   assign err_cnt = err_cnt_q;
   assign err_sum = err_sum_q;
   assign max_err = max_err_q;
   assign worst_a = worst_a_q;
   assign worst_b = worst_b_q;

`ifdef MUL4_ERR_BIAS_EN
   logic signed [BIASW-1:0] err_bias_q, err_bias_d;

   always_comb begin
      err_bias_d = err_bias_q;
      if (clr) begin
         err_bias_d = '0;
      end else if (vld) begin
         err_bias_d = err_bias_q + {{(BIASW-PRW-1){diff[PRW]}}, diff};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_bias_q <= '0;
      end else begin
         err_bias_q <= err_bias_d;
      end
   end

   assign err_bias = err_bias_q;
`endif

endmodule

// File: rtl/mul4_err_sweep.sv
// -----------------------------------------------------------------------------
// mul4_err_sweep
// Exhaustive error characterisation of a 4x4 (approximate) multiplier.
// Presents all 256 operand pairs {mul_a, mul_b} = idx, one per cycle, waits
// MUL_LAT cycles for the multiplier pipeline to drain, then pulses done with
// the final error statistics. A {valid, A, B} shift register of depth MUL_LAT
// aligns each vector with the product it produced.
//
// Optional: define MUL4_ERR_BIAS_EN to add output err_bias (signed sum of
// mul_r - A*B).
//
// Parameter:
//   MUL_LAT   multiplier latency in cycles, 0 (combinational) .. 4
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               request a sweep (sampled only in IDLE)
//   busy                high in SWEEP and DRAIN
//   done                one-cycle pulse when statistics are final
//   mul_a, mul_b        operands to the multiplier under test
//   mul_r               product from the multiplier under test
//   err_cnt, err_sum,   error statistics, held from DONE until the next
//   max_err,            accepted start
//   worst_a, worst_b
//   err_bias            (MUL4_ERR_BIAS_EN) signed error sum
// -----------------------------------------------------------------------------
module mul4_err_sweep
   import mul4_err_pkg::*;
#(
   parameter int MUL_LAT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [OPW-1:0]   mul_a,
   output logic [OPW-1:0]   mul_b,
   input  logic [PRW-1:0]   mul_r,
   output logic [CNTW-1:0]  err_cnt,
   output logic [SUMW-1:0]  err_sum,
   output logic [PRW-1:0]   max_err,
   output logic [OPW-1:0]   worst_a,
   output logic [OPW-1:0]   worst_b
`ifdef MUL4_ERR_BIAS_EN
   ,
   output logic signed [BIASW-1:0] err_bias
`endif
);

   localparam logic [2:0] DRN_LAST = 3'((MUL_LAT > 0) ? (MUL_LAT - 1) : 0);

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [2:0]       drn_q, drn_d;
   logic             clr;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      drn_d   = drn_q;
      clr     = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SWEEP;
               idx_d   = '0;
               drn_d   = '0;
               clr     = 1'b1;
            end
         end
         SWEEP: begin
            busy = 1'b1;
            if (idx_q == IDXW'(NVEC - 1)) begin
               if (MUL_LAT > 0) begin
                  // Hold (15,15) on the operands while the pipeline drains.
                  state_d = DRAIN;
                  drn_d   = '0;
               end else begin
                  state_d = DONE;
                  idx_d   = '0;
               end
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (drn_q == DRN_LAST) begin
               state_d = DONE;
               idx_d   = '0;
            end else begin
               drn_d = drn_q + 3'd1;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         drn_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         drn_q   <= drn_d;
      end
   end

   assign mul_a = idx_q[IDXW-1:OPW];
   assign mul_b = idx_q[OPW-1:0];

   // ------------------------------------------------------- alignment
   logic [IDXW:0] stg_in;
   logic [IDXW:0] stg_out;

   assign stg_in = {(state_q == SWEEP), idx_q};

   generate
      if (MUL_LAT == 0) begin : g_comb
         assign stg_out = stg_in;
      end else begin : g_pipe
         logic [IDXW:0] pipe_q [MUL_LAT];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < MUL_LAT; i++) begin
                  pipe_q[i] <= '0;
               end
            end else begin
               pipe_q[0] <= stg_in;
               for (int i = 1; i < MUL_LAT; i++) begin
                  pipe_q[i] <= pipe_q[i-1];
               end
            end
         end

         assign stg_out = pipe_q[MUL_LAT-1];
      end
   endgenerate

   // -------------------------------------------------------- datapath
   mul4_err_acc u_acc (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .vld      (stg_out[IDXW]),
      .a        (stg_out[IDXW-1:OPW]),
      .b        (stg_out[OPW-1:0]),
      .r        (mul_r),
      .err_cnt  (err_cnt),
      .err_sum  (err_sum),
      .max_err  (max_err),
      .worst_a  (worst_a),
      .worst_b  (worst_b)
`ifdef MUL4_ERR_BIAS_EN
      ,
      .err_bias (err_bias)
`endif
   );

endmodule

// File: tb/tb_mul4_err_sweep.sv
// -----------------------------------------------------------------------------
// tb_mul4_err_sweep
// Two sweep instances: dut0 (MUL_LAT=0) around a combinational stub whose
// behaviour is selected by mode0, and dut2 (MUL_LAT=2) around a two-stage
// registered stub computing (A*B) & 8'hFE.
// -----------------------------------------------------------------------------
module tb_mul4_err_sweep;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic        rst;
   logic        start0, start2;
   int          mode0;

   logic        busy0, done0, busy2, done2;
   logic [3:0]  a0, b0, a2, b2, wa0, wb0, wa2, wb2;
   logic [7:0]  r0, r2, max0, max2;
   logic [8:0]  cnt0, cnt2;
   logic [15:0] sum0, sum2;
`ifdef MUL4_ERR_BIAS_EN
   logic signed [16:0] bias0, bias2;
`endif

   function automatic logic [7:0] stub_fn(int mode, logic [3:0] a, logic [3:0] b);
      logic [7:0] p;
      p = {4'b0, a} * {4'b0, b};
      case (mode)
         0:       return p;
         1:       return p & 8'hFE;
         2:       return 8'h00;
         3:       return p + 8'd3;
         default: return p ^ 8'h55;
      endcase
   endfunction

   always_comb r0 = stub_fn(mode0, a0, b0);

   logic [7:0] s1 = 8'h0, s2 = 8'h0;
   always @(posedge clk) begin
      s1 <= stub_fn(1, a2, b2);
      s2 <= s1;
   end
   assign r2 = s2;

   mul4_err_sweep #(.MUL_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
      .mul_a(a0), .mul_b(b0), .mul_r(r0), .err_cnt(cnt0), .err_sum(sum0),
      .max_err(max0), .worst_a(wa0), .worst_b(wb0)
`ifdef MUL4_ERR_BIAS_EN
      , .err_bias(bias0)
`endif
   );

   mul4_err_sweep #(.MUL_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
      .mul_a(a2), .mul_b(b2), .mul_r(r2), .err_cnt(cnt2), .err_sum(sum2),
      .max_err(max2), .worst_a(wa2), .worst_b(wb2)
`ifdef MUL4_ERR_BIAS_EN
      , .err_bias(bias2)
`endif
   );

   typedef struct {
      int mode; int lat; bit pulse50;
      int cnt; int sum; int mx; int wa; int wb; int bias;
   } vec_t;

   typedef struct {
      int cnt; int sum; int mx; int wa; int wb; int bias; int done_cyc;
   } exp_t;

   exp_t sb_q[$];
   int checks = 0;
   int failures = 0;

   // snapshot of the selected DUT's outputs
   bit s_busy, s_done;
   int s_a, s_b, s_cnt, s_sum, s_max, s_wa, s_wb, s_bias;

   task automatic snap(int lat);
      if (lat == 0) begin
         s_busy = busy0; s_done = done0; s_a = a0; s_b = b0;
         s_cnt = cnt0; s_sum = sum0; s_max = max0; s_wa = wa0; s_wb = wb0;
`ifdef MUL4_ERR_BIAS_EN
         s_bias = int'(bias0);
`else
         s_bias = 0;
`endif
      end else begin
         s_busy = busy2; s_done = done2; s_a = a2; s_b = b2;
         s_cnt = cnt2; s_sum = sum2; s_max = max2; s_wa = wa2; s_wb = wb2;
`ifdef MUL4_ERR_BIAS_EN
         s_bias = int'(bias2);
`else
         s_bias = 0;
`endif
      end
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t model(int mode, bit pulse50);
      vec_t v;
      v = '{mode, 0, pulse50, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 256; i++) begin
         int a, b, d, ae;
         a = i / 16;
         b = i % 16;
         d = int'(stub_fn(mode, 4'(a), 4'(b))) - a * b;
         ae = (d < 0) ? -d : d;
         if (ae != 0) v.cnt++;
         v.sum += ae;
         v.bias += d;
         if (ae > v.mx) begin
            v.mx = ae; v.wa = a; v.wb = b;
         end
      end
      return v;
   endfunction

   // Waits for done of the selected DUT (sweep accepted at edge k), checking
   // the operand sequence and busy length on the way, then pops and compares.
   task automatic wait_done(int lat, int k, bit pulse50, string tag);
      int busy_n = 0;
      int seq_bad = 0;
      bit got = 0;
      exp_t e;
      for (int t = 0; t < 600 && !got; t++) begin
         int rel;
         snap(lat);
         rel = cyc - k - 1;
         if (s_busy) busy_n++;
         if (rel >= 0 && rel < 256) begin
            if (s_a * 16 + s_b != rel || !s_busy) seq_bad++;
         end else if (s_busy && s_a * 16 + s_b != 255) begin
            seq_bad++;
         end
         if (pulse50) begin
            if (lat == 0) start0 = (cyc == k + 50);
            else          start2 = (cyc == k + 50);
         end
         if (s_done) begin
            got = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!got) begin
         chk({tag, "_done_timeout"}, 0, 1);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
         return;
      end
      e = sb_q.pop_front();
      $display("sweep %s: lat=%0d cnt=%0d sum=%0d max=%0d worst=(%0d,%0d) done@%0d busy=%0d",
               tag, lat, s_cnt, s_sum, s_max, s_wa, s_wb, cyc - k, busy_n);
      chk({tag, "_done_cycle"}, cyc, e.done_cyc);
      chk({tag, "_err_cnt"}, s_cnt, e.cnt);
      chk({tag, "_err_sum"}, s_sum, e.sum);
      chk({tag, "_max_err"}, s_max, e.mx);
      chk({tag, "_worst_a"}, s_wa, e.wa);
      chk({tag, "_worst_b"}, s_wb, e.wb);
`ifdef MUL4_ERR_BIAS_EN
      chk({tag, "_err_bias"}, s_bias, e.bias);
`endif
      chk({tag, "_busy_len"}, busy_n, 256 + lat);
      chk({tag, "_vec_seq_errs"}, seq_bad, 0);
      @(negedge clk);
      snap(lat);
      chk({tag, "_done_one_cycle"}, int'(s_done), 0);
      chk({tag, "_idle_after_done"}, int'(s_busy), 0);
   endtask

   task automatic run_sweep(vec_t v, string tag);
      int k;
      @(negedge clk);
      if (v.lat == 0) begin
         mode0 = v.mode;
         start0 = 1'b1;
      end else begin
         start2 = 1'b1;
      end
      k = cyc;
      sb_q.push_back('{v.cnt, v.sum, v.mx, v.wa, v.wb, v.bias, k + 257 + v.lat});
      @(negedge clk);
      start0 = 1'b0;
      start2 = 1'b0;
      wait_done(v.lat, k, v.pulse50, tag);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[1] = '{1, 0, 0, 64, 64, 1, 1, 1, -64};
      vecs[2] = '{2, 0, 0, 225, 14400, 225, 15, 15, -14400};
      vecs[3] = '{1, 2, 0, 64, 64, 1, 1, 1, -64};
      vecs[4] = model(3, 0);
      vecs[5] = model(4, 0);
      vecs[6] = '{1, 0, 1, 64, 64, 1, 1, 1, -64};

      rst = 1'b1;
      start0 = 1'b0;
      start2 = 1'b0;
      mode0 = 0;
      repeat (3) @(negedge clk);

      // reset state
      snap(0);
      chk("rst_busy", int'(s_busy), 0);
      chk("rst_done", int'(s_done), 0);
      chk("rst_ab", s_a * 16 + s_b, 0);
      chk("rst_stats", s_cnt + s_sum + s_max + s_wa + s_wb, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         run_sweep(vecs[i], tag);
      end

      // abort mid-sweep with reset, then restart
      begin
         bit hit = 0;
         int seen = 0;
         @(negedge clk);
         mode0 = 1;
         start0 = 1'b1;
         @(negedge clk);
         start0 = 1'b0;
         for (int t = 0; t < 300 && !hit; t++) begin
            if (a0 == 4'd6 && b0 == 4'd4) hit = 1;
            else @(negedge clk);
         end
         chk("abort_reach_idx100", int'(hit), 1);
         chk("abort_pre_cnt_nonzero", int'(cnt0 != 0), 1);
         rst = 1'b1;
         #1;
         snap(0);
         $display("abort: busy=%0d cnt=%0d sum=%0d max=%0d ab=%0d", s_busy, s_cnt, s_sum, s_max, s_a * 16 + s_b);
         chk("abort_busy", int'(s_busy), 0);
         chk("abort_cnt", s_cnt, 0);
         chk("abort_sum", s_sum, 0);
         chk("abort_max", s_max, 0);
         chk("abort_worst", s_wa * 16 + s_wb, 0);
         chk("abort_ab", s_a * 16 + s_b, 0);
         repeat (2) @(negedge clk);
         rst = 1'b0;
         for (int t = 0; t < 300; t++) begin
            if (done0 || busy0) seen++;
            @(negedge clk);
         end
         chk("abort_no_done", seen, 0);
         run_sweep(vecs[1], "restart");
      end

      // start held high: second sweep right after DONE with cleared stats
      begin
         int k1;
         @(negedge clk);
         mode0 = 2;
         start0 = 1'b1;
         k1 = cyc;
         sb_q.push_back('{225, 14400, 225, 15, 15, -14400, k1 + 257});
         sb_q.push_back('{0, 0, 0, 0, 0, 0, k1 + 258 + 257});
         @(negedge clk);
         wait_done(0, k1, 1'b0, "hold1");
         mode0 = 0;
         @(negedge clk);
         start0 = 1'b0;
         wait_done(0, k1 + 258, 1'b0, "hold2");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
